// File: rtl/permutation_scheduler_pkg.sv
// Shared types and constants for the Ascon permutation round scheduler.
// The round count is chosen per request; the last round always uses index NB_ROUNDS_MAX-1.
package permutation_scheduler_pkg;

  localparam int NB_ROUNDS_MAX = 12;
  localparam int CNT_W         = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } type_sched_state;

  localparam logic [1:0] ROUNDS_P12 = 2'b00;
  localparam logic [1:0] ROUNDS_P8  = 2'b01;
  localparam logic [1:0] ROUNDS_P6  = 2'b10;

  // A shorter permutation starts later in the constant table so that it still ends on the last constant.
  // The reserved encoding runs the full permutation.
  function automatic logic [CNT_W-1:0] start_index(input logic [1:0] sel);
    logic [CNT_W-1:0] idx;
    case (sel)
      ROUNDS_P8: idx = CNT_W'(NB_ROUNDS_MAX - 8);
      ROUNDS_P6: idx = CNT_W'(NB_ROUNDS_MAX - 6);
      default:   idx = CNT_W'(0);
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/permutation_scheduler_round_counter.sv
// Round-constant index counter: loadable start value and a flag on the final round.
// The count saturates at the final index, so it cannot wrap.
module permutation_scheduler_round_counter
  import permutation_scheduler_pkg::*;
(
  input  logic             clock_i,
  input  logic             resetb_i,
  input  logic             clear,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             last
);

  assign last = (cnt == CNT_W'(NB_ROUNDS_MAX - 1));

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (inc && !last) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/permutation_scheduler.sv
// Ascon permutation scheduler: steps the round index for p^12/p^8/p^6 requests.
// It also drives the datapath input-mux select and the state-register load enable.
module permutation_scheduler
  import permutation_scheduler_pkg::*;
(
  input  logic             clock_i,
  input  logic             resetb_i,
  input  logic             start_i,
  input  logic [1:0]       rounds_sel_i,
  input  logic             abort_i,
  input  logic             done_ack_i,
  output logic             ready_o,
  output logic [CNT_W-1:0] round_o,
  output logic             init_sel_o,
  output logic             en_reg_state_o,
  output logic             busy_o,
  output logic             done_o
);

  type_sched_state  state, state_next;
  logic             first;
  logic             cnt_clear, cnt_load, cnt_inc, cnt_last;
  logic [CNT_W-1:0] cnt;

  permutation_scheduler_round_counter u_round_counter (
    .clock_i  (clock_i),
    .resetb_i (resetb_i),
    .clear    (cnt_clear),
    .load     (cnt_load),
    .load_val (start_index(rounds_sel_i)),
    .inc      (cnt_inc),
    .cnt      (cnt),
    .last     (cnt_last)
  );

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // init_sel is raised only on the first RUN cycle, so the external state enters the datapath once.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      first <= 1'b0;
    end else if (abort_i) begin
      first <= 1'b0;
    end else if (cnt_load) begin
      first <= 1'b1;
    end else if (state == RUN) begin
      first <= 1'b0;
    end
  end

  always_comb begin
    state_next = state;
    cnt_clear  = 1'b0;
    cnt_load   = 1'b0;
    cnt_inc    = 1'b0;
    if (abort_i) begin
      state_next = IDLE;
      cnt_clear  = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            state_next = RUN;
            cnt_load   = 1'b1;
          end
        end
        RUN: begin
          if (cnt_last) begin
            state_next = DONE;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        DONE: begin
          if (done_ack_i) begin
            state_next = IDLE;
            cnt_clear  = 1'b1;
          end
        end
        default: begin
          state_next = IDLE;
          cnt_clear  = 1'b1;
        end
      endcase
    end
  end

  // An aborted round must not load the state register, even though the index is still on the bus.
  assign ready_o        = (state == IDLE);
  assign busy_o         = (state == RUN);
  assign done_o         = (state == DONE);
  assign en_reg_state_o = (state == RUN) && !abort_i;
  assign init_sel_o     = (state == RUN) && first;
  assign round_o        = cnt;

endmodule
